// File: rtl/ddr3_cmd_responder.sv
// DDR3 command-bus responder: decodes commands, tracks per-bank open rows and timers,
// returns address-derived read bursts CL cycles after each legal RD. Stats via DDR3_RESP_STATS_EN.
module ddr3_cmd_responder #(
  parameter int CL   = 6,
  parameter int TRCD = 6,
  parameter int TRP  = 6,
  parameter int TRAS = 15,
  parameter int TCCD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [2:0]  ba,
  input  logic [13:0] addr,
  output logic        rd_valid,
  output logic [63:0] rd_data,
  output logic [7:0]  bank_open,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [15:0] viol_count,
  output logic [31:0] act_count,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] pre_count
);

  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;

  localparam logic [4:0] CNT_MAX = 5'd31;
  localparam logic [4:0] T_RCD   = 5'(TRCD);
  localparam logic [4:0] T_RP    = 5'(TRP);
  localparam logic [4:0] T_RAS   = 5'(TRAS);
  localparam logic [4:0] T_CCD   = 5'(TCCD);

  // Age counters hold d = cycles since the last command of that kind (1 the cycle after it).
  logic [7:0]  open_q;
  logic [13:0] row_q     [8];
  logic [4:0]  act_age_q [8];
  logic [4:0]  pre_age_q [8];
  logic [4:0]  rw_age_q;

  logic [CL-1:0] pipe_v;
  logic [63:0]   pipe_d [CL];

  logic        err_valid_q;
  logic [2:0]  err_code_q;
  logic [15:0] viol_count_q;

  logic       cmd_en;
  logic [2:0] cmd;
  logic       pre_all_ras;
  logic [2:0] err_c;
  logic       legal;
  logic       do_act, do_rd, do_wr, do_pre;
  logic [31:0] rd_word;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == CNT_MAX) ? v : v + 5'd1;
  endfunction

  always_comb begin
    cmd_en      = cke & ~cs_n;
    cmd         = {ras_n, cas_n, we_n};
    pre_all_ras = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (open_q[b] && (act_age_q[b] < T_RAS)) pre_all_ras = 1'b1;
    end
    err_c = 3'd0;
    if (cmd_en) begin
      case (cmd)
        CMD_RD, CMD_WR: begin
          if (!open_q[ba])                err_c = 3'd1;
          else if (act_age_q[ba] < T_RCD) err_c = 3'd3;
          else if (rw_age_q < T_CCD)      err_c = 3'd6;
        end
        CMD_ACT: begin
          if (open_q[ba])                 err_c = 3'd2;
          else if (pre_age_q[ba] < T_RP)  err_c = 3'd4;
        end
        CMD_PRE: begin
          if (addr[10] ? pre_all_ras : (open_q[ba] && (act_age_q[ba] < T_RAS)))
            err_c = 3'd5;
        end
        CMD_REF: begin
          if (|open_q) err_c = 3'd7;
        end
        default: ;
      endcase
    end
    legal   = cmd_en && (err_c == 3'd0);
    do_act  = legal && (cmd == CMD_ACT);
    do_rd   = legal && (cmd == CMD_RD);
    do_wr   = legal && (cmd == CMD_WR);
    do_pre  = legal && (cmd == CMD_PRE);
    rd_word = {5'b0, ba, row_q[ba], addr[9:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q   <= '0;
      rw_age_q <= CNT_MAX;
      for (int b = 0; b < 8; b++) begin
        row_q[b]     <= '0;
        act_age_q[b] <= CNT_MAX;
        pre_age_q[b] <= CNT_MAX;
      end
    end else begin
      rw_age_q <= sat_inc(rw_age_q);
      for (int b = 0; b < 8; b++) begin
        act_age_q[b] <= sat_inc(act_age_q[b]);
        pre_age_q[b] <= sat_inc(pre_age_q[b]);
      end
      if (do_act) begin
        open_q[ba]    <= 1'b1;
        row_q[ba]     <= addr;
        act_age_q[ba] <= 5'd1;
      end
      if (do_rd || do_wr) begin
        rw_age_q <= 5'd1;
        if (addr[10]) begin
          open_q[ba]    <= 1'b0;
          pre_age_q[ba] <= 5'd1;
        end
      end
      // A PRE to a closed bank leaves its tRP timer untouched.
      if (do_pre) begin
        for (int b = 0; b < 8; b++) begin
          if (open_q[b] && (addr[10] || (ba == 3'(b)))) begin
            open_q[b]    <= 1'b0;
            pre_age_q[b] <= 5'd1;
          end
        end
      end
    end
  end

  // rd_valid and err_valid are single-cycle strobes with no back-pressure; the
  // consumer must take rd_data/err_code in the cycle the strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v       <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= 3'd0;
      viol_count_q <= 16'd0;
      for (int i = 0; i < CL; i++) pipe_d[i] <= '0;
    end else begin
      // Data only advances alongside a valid entry, so the last stage holds the latest burst.
      for (int i = CL - 1; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
      pipe_v[0] <= do_rd;
      if (do_rd) pipe_d[0] <= {rd_word, ~rd_word};
      err_valid_q <= (err_c != 3'd0);
      if (err_c != 3'd0) begin
        err_code_q <= err_c;
        if (viol_count_q != 16'hFFFF) viol_count_q <= viol_count_q + 16'd1;
      end
    end
  end

  assign rd_valid   = pipe_v[CL-1];
  assign rd_data    = pipe_d[CL-1];
  assign bank_open  = open_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign viol_count = viol_count_q;

`ifdef DDR3_RESP_STATS_EN
  logic [31:0] stat_act_q, stat_rd_q, stat_wr_q, stat_pre_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_act_q <= '0;
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_pre_q <= '0;
    end else begin
      if (do_act) stat_act_q <= stat_act_q + 32'd1;
      if (do_rd)  stat_rd_q  <= stat_rd_q + 32'd1;
      if (do_wr)  stat_wr_q  <= stat_wr_q + 32'd1;
      if (do_pre) stat_pre_q <= stat_pre_q + 32'd1;
    end
  end

  assign act_count = stat_act_q;
  assign rd_count  = stat_rd_q;
  assign wr_count  = stat_wr_q;
  assign pre_count = stat_pre_q;
`else
  assign act_count = 32'd0;
  assign rd_count  = 32'd0;
  assign wr_count  = 32'd0;
  assign pre_count = 32'd0;
`endif

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed bench for ddr3_cmd_responder: commands push expected read/error responses into
// queues; a negedge monitor pops and compares whenever rd_valid or err_valid is seen.
module tb_ddr3_cmd_responder;

  localparam int CL = 6;

  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic [7:0]  bank_open;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [15:0] viol_count;
  logic [31:0] act_count, rd_count, wr_count, pre_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [95:0] exp_q[$];
  logic [34:0] exp_err_q[$];
  logic [95:0] rd_e;
  logic [34:0] err_e;

  ddr3_cmd_responder #(.CL(CL)) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .bank_open(bank_open),
    .err_valid(err_valid), .err_code(err_code), .viol_count(viol_count),
    .act_count(act_count), .rd_count(rd_count), .wr_count(wr_count), .pre_count(pre_count)
  );

  // Clock and cycle index: the command driven after posedge k is sampled as cycle k.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [2:0] b, input logic [13:0] a);
    @(negedge clk);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cs_n = 1'b1;
      {ras_n, cas_n, we_n} = C_NOP;
    end
  endtask

  task automatic push_rd(input logic [63:0] d);
    exp_q.push_back({32'(cyc + CL), d});
  endtask

  task automatic push_err(input logic [2:0] code);
    exp_err_q.push_back({32'(cyc + 1), code});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual_cycle=%0d data=%0h required=none", cyc, rd_data);
      end else begin
        rd_e = exp_q.pop_front();
        check("rd_cycle", 64'(cyc), 64'(rd_e[95:64]));
        check("rd_data", rd_data, rd_e[63:0]);
      end
    end
    if (err_valid === 1'b1) begin
      if (exp_err_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL err_unexpected actual_cycle=%0d code=%0d required=none", cyc, err_code);
      end else begin
        err_e = exp_err_q.pop_front();
        check("err_cycle", 64'(cyc), 64'(err_e[34:3]));
        check("err_code", 64'(err_code), 64'(err_e[2:0]));
      end
    end
  end

  initial begin
    cke = 1'b1;
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
    ba = '0;
    addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
    check("reset_bank_open", 64'(bank_open), 64'd0);
    check("reset_err_valid", 64'(err_valid), 64'd0);
    check("reset_viol", 64'(viol_count), 64'd0);

    // Legal ACT then RD after exactly tRCD
    send(C_ACT, 3'd2, 14'h1234);
    idle(5);
    send(C_RD, 3'd2, 14'h0040);
    push_rd(64'h0248D040_FDB72FBF);
    idle(8);
    check("t1_bank_open", 64'(bank_open), 64'h04);
    check("t1_viol", 64'(viol_count), 64'd0);

    // tRCD violation: RD one cycle early
    send(C_ACT, 3'd1, 14'h0011);
    idle(4);
    send(C_RD, 3'd1, 14'h0000);
    push_err(3'd3);
    idle(CL + 2);
    check("t2_viol", 64'(viol_count), 64'd1);
    check("t2_bank_open", 64'(bank_open), 64'h06);

    // cke low: bus ignored, so RD to closed bank 7 raises nothing
    idle(1);
    cke = 1'b0;
    send(C_RD, 3'd7, 14'h0000);
    idle(1);
    cke = 1'b1;

    // Closed-bank RD, double ACT, early PRE
    send(C_RD, 3'd5, 14'h0000);
    push_err(3'd1);
    idle(1);
    send(C_ACT, 3'd5, 14'h0005);
    send(C_ACT, 3'd5, 14'h0005);
    push_err(3'd2);
    idle(8);
    send(C_PRE, 3'd5, 14'h0000);
    push_err(3'd5);
    idle(3);
    check("t3_bank_open", 64'(bank_open), 64'h26);
    check("t3_viol", 64'(viol_count), 64'd4);

    // tCCD: second RD 2 cycles after first is dropped, 4 cycles after is legal
    send(C_ACT, 3'd0, 14'h0100);
    send(C_ACT, 3'd3, 14'h2ABC);
    idle(4);
    send(C_RD, 3'd0, 14'h03FF);
    push_rd(64'h000403FF_FFFBFC00);
    idle(1);
    send(C_RD, 3'd3, 14'h0155);
    push_err(3'd6);
    idle(1);
    send(C_RD, 3'd3, 14'h0155);
    push_rd(64'h03AAF155_FC550EAA);
    idle(CL + 2);
    check("t4_viol", 64'(viol_count), 64'd5);
    check("t4_bank_open", 64'(bank_open), 64'h2F);

    // Auto-precharge RD, tRP after it, REF with banks open
    send(C_ACT, 3'd4, 14'h0444);
    idle(5);
    send(C_RD, 3'd4, 14'h0421);
    push_rd(64'h04111021_FBEEEFDE);
    idle(4);
    check("t5_autopre_close", 64'(bank_open), 64'h2F);
    send(C_ACT, 3'd4, 14'h0444);
    push_err(3'd4);
    send(C_ACT, 3'd4, 14'h0444);
    send(C_REF, 3'd0, 14'h0000);
    push_err(3'd7);
    idle(CL + 2);
    check("t5_viol", 64'(viol_count), 64'd7);
    check("t5_err_hold", 64'(err_code), 64'd7);
    check("t5_bank_open", 64'(bank_open), 64'h3F);

    // Legal WR, PRE to an open bank and to a closed bank
    send(C_WR, 3'd0, 14'h0010);
    idle(3);
    send(C_PRE, 3'd2, 14'h0000);
    idle(1);
    send(C_PRE, 3'd7, 14'h0000);
    idle(2);
    check("t6_pre_bank_open", 64'(bank_open), 64'h3B);
    check("t6_viol", 64'(viol_count), 64'd7);

    // Reset while a read is in flight
    send(C_ACT, 3'd6, 14'h0006);
    idle(5);
    send(C_RD, 3'd6, 14'h0001);
    idle(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_bank_open", 64'(bank_open), 64'd0);
    check("rst_viol", 64'(viol_count), 64'd0);
    check("rst_err_valid", 64'(err_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(CL + 2);

    // Stats sequence: 3 ACT, 2 RD, 1 PRE-all
    send(C_ACT, 3'd0, 14'h0ABC);
    send(C_ACT, 3'd1, 14'h0001);
    send(C_ACT, 3'd2, 14'h0002);
    idle(3);
    send(C_RD, 3'd0, 14'h0001);
    push_rd(64'h002AF001_FFD50FFE);
    idle(3);
    send(C_RD, 3'd1, 14'h0002);
    push_rd(64'h01000402_FEFFFBFD);
    idle(9);
    send(C_PRE, 3'd0, 14'h0400);
    idle(4);
    check("t7_bank_open", 64'(bank_open), 64'd0);
    check("t7_viol", 64'(viol_count), 64'd0);
`ifdef DDR3_RESP_STATS_EN
    check("act_count", 64'(act_count), 64'd3);
    check("rd_count", 64'(rd_count), 64'd2);
    check("wr_count", 64'(wr_count), 64'd0);
    check("pre_count", 64'(pre_count), 64'd1);
`else
    check("act_count", 64'(act_count), 64'd0);
    check("rd_count", 64'(rd_count), 64'd0);
    check("wr_count", 64'(wr_count), 64'd0);
    check("pre_count", 64'(pre_count), 64'd0);
`endif

    idle(CL + 2);
    check("rd_queue_left", 64'(exp_q.size()), 64'd0);
    check("err_queue_left", 64'(exp_err_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
